// File: rtl/led_pkg.sv
// Shared timing, colour and state definitions for the WS2812 strip driver.
package led_pkg;

   localparam int NBITS  = 120;
   localparam int TBIT   = 63;
   localparam int T0H    = 20;
   localparam int T1H    = 40;
   localparam int TLATCH = 2600;

   // 24-bit colours in wire order: G, R, B
   localparam logic [23:0] OFF    = 24'h00_00_00;
   localparam logic [23:0] RED    = 24'h00_FF_00;
   localparam logic [23:0] ORANGE = 24'h80_FF_00;
   localparam logic [23:0] GREEN  = 24'hFF_00_00;
   localparam logic [23:0] CYAN   = 24'hFF_00_FF;
   localparam logic [23:0] BLUE   = 24'h00_00_FF;
   localparam logic [23:0] VIOLET = 24'h00_80_FF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HIGH  = 2'd1,
      LOW   = 2'd2,
      LATCH = 2'd3
   } led_state_t;

endpackage

// File: rtl/led_bit_cell.sv
// Per-bit waveform timer: high phase of T0H/T1H cycles, then low phase to fill TBIT.
module led_bit_cell #(
   parameter int TBIT = led_pkg::TBIT,
   parameter int T0H  = led_pkg::T0H,
   parameter int T1H  = led_pkg::T1H,
   parameter int CW   = 12
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic bit_val,
   output logic high_done,
   output logic bit_end
);

   logic          active;
   logic          phase_hi;
   logic          bit_q;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         active   <= 1'b0;
         phase_hi <= 1'b0;
         bit_q    <= 1'b0;
         cnt      <= '0;
      end else if (start) begin
         active   <= 1'b1;
         phase_hi <= 1'b1;
         bit_q    <= bit_val;
         cnt      <= bit_val ? CW'(T1H - 1) : CW'(T0H - 1);
      end else if (active) begin
         if (cnt == '0) begin
            if (phase_hi) begin
               phase_hi <= 1'b0;
               cnt      <= bit_q ? CW'(TBIT - T1H - 1) : CW'(TBIT - T0H - 1);
            end else begin
               active <= 1'b0;
            end
         end else begin
            cnt <= cnt - CW'(1);
         end
      end
   end

   // Terminal-count strobes mark the last cycle of each phase
   assign high_done = active &&  phase_hi && (cnt == '0);
   assign bit_end   = active && !phase_hi && (cnt == '0);

endmodule

// File: rtl/led_strip_driver.sv
// WS2812 frame serializer with a one-entry pending frame buffer (latest load wins).
//   state | meaning
//   IDLE  | line low, waiting for load
//   HIGH  | high part of current bit (T1H or T0H cycles)
//   LOW   | low remainder of current bit, TBIT total
//   LATCH | TLATCH low cycles, frame_done on the last one
module led_strip_driver
   import led_pkg::led_state_t, led_pkg::IDLE, led_pkg::HIGH, led_pkg::LOW, led_pkg::LATCH;
#(
   parameter int NBITS  = led_pkg::NBITS,
   parameter int TBIT   = led_pkg::TBIT,
   parameter int T0H    = led_pkg::T0H,
   parameter int T1H    = led_pkg::T1H,
   parameter int TLATCH = led_pkg::TLATCH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NBITS-1:0] grb_seq,
   input  logic             load,
   output logic             dout,
   output logic             busy,
   output logic             frame_done
);

   localparam int CW = $clog2(TLATCH + 1);
   localparam int BW = $clog2(NBITS + 1);

   led_state_t       state;
   logic [NBITS-1:0] shift_q;
   logic [NBITS-1:0] pend_q;
   logic             pend_v;
   logic [BW-1:0]    bit_cnt;
   logic [CW-1:0]    latch_cnt;
   logic             start;
   logic             next_bit;
   logic             high_done;
   logic             bit_end;
   logic             latch_final;
   logic             more_bits;

   assign latch_final = (state == LATCH) && (latch_cnt == '0);
   assign more_bits   = (bit_cnt != BW'(NBITS - 1));

   // Tell the bit cell which bit begins on the edge that enters HIGH
   always_comb begin
      start    = 1'b0;
      next_bit = 1'b0;
      case (state)
         IDLE: begin
            start    = load;
            next_bit = grb_seq[NBITS-1];
         end
         LOW: begin
            start    = bit_end && more_bits;
            next_bit = shift_q[NBITS-2];
         end
         LATCH: begin
            start    = latch_final && (load || pend_v);
            next_bit = load ? grb_seq[NBITS-1] : pend_q[NBITS-1];
         end
         default: begin
            start    = 1'b0;
            next_bit = 1'b0;
         end
      endcase
   end

   led_bit_cell #(
      .TBIT (TBIT),
      .T0H  (T0H),
      .T1H  (T1H),
      .CW   (CW)
   ) u_bit_cell (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .bit_val   (next_bit),
      .high_done (high_done),
      .bit_end   (bit_end)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         dout       <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         pend_v     <= 1'b0;
         bit_cnt    <= '0;
         latch_cnt  <= '0;
      end else begin
         frame_done <= 1'b0;
         // A load on the final latch cycle is consumed directly below
         if (load && (state != IDLE) && !latch_final) begin
            pend_q <= grb_seq;
            pend_v <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (load) begin
                  shift_q <= grb_seq;
                  bit_cnt <= '0;
                  state   <= HIGH;
                  dout    <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            HIGH: begin
               if (high_done) begin
                  state <= LOW;
                  dout  <= 1'b0;
               end
            end
            LOW: begin
               if (bit_end) begin
                  shift_q <= shift_q << 1;
                  bit_cnt <= bit_cnt + BW'(1);
                  if (more_bits) begin
                     state <= HIGH;
                     dout  <= 1'b1;
                  end else begin
                     state      <= LATCH;
                     latch_cnt  <= CW'(TLATCH - 1);
                     frame_done <= (TLATCH == 1);
                  end
               end
            end
            LATCH: begin
               if (latch_cnt != '0) begin
                  latch_cnt  <= latch_cnt - CW'(1);
                  frame_done <= (latch_cnt == CW'(1));
               end else if (load || pend_v) begin
                  shift_q <= load ? grb_seq : pend_q;
                  pend_v  <= 1'b0;
                  bit_cnt <= '0;
                  state   <= HIGH;
                  dout    <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
